// File: rtl/cordic_atan_stream_rom.sv
// Arctangent table for the CORDIC core. It has a registered random-access read port
// and a valid/ready stream port that walks consecutive table entries.
module cordic_atan_stream_rom #(
    parameter int DATA_W = 32,
    parameter int FRAC_W = 30,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_idx,
    input  logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              s_valid,
    input  logic              s_ready,
    output logic [DATA_W-1:0] s_data,
    output logic [ADDR_W-1:0] s_idx,
    output logic              s_last
);

    localparam int PREC = 128;
    localparam int CW   = PREC + 8;
    localparam int ROWS = 2 ** ADDR_W;

    typedef logic [CW-1:0] wide_t;
    typedef enum logic {IDLE, RUN} state_t;

    // atan(1/n) as a Taylor series at 2^-128 resolution. That leaves enough guard bits
    // for the final rounding to match the exact value, even for near-ties at i = FRAC_W+1.
    function automatic wide_t atan_recip(input wide_t n);
        wide_t power;
        wide_t nsq;
        wide_t sum;
        wide_t term;
        power = (wide_t'(1) << PREC) / n;
        nsq   = n * n;
        sum   = '0;
        for (int k = 0; k < 100; k++) begin
            term = power / wide_t'(2 * k + 1);
            if (k % 2 == 0) sum = sum + term;
            else            sum = sum - term;
            power = power / nsq;
        end
        return sum;
    endfunction

    function automatic logic [DATA_W-1:0] atan_entry(input int i);
        wide_t exact;
        wide_t rounded;
        if (i == 0)
            exact = atan_recip(wide_t'(2)) + atan_recip(wide_t'(3));
        else if (i > FRAC_W + 1)
            exact = '0;
        else
            exact = atan_recip(wide_t'(1) << i);
        rounded = (exact + (wide_t'(1) << (PREC - FRAC_W - 1))) >> (PREC - FRAC_W);
        return rounded[DATA_W-1:0];
    endfunction

    logic [DATA_W-1:0] rom [ROWS];

    for (genvar g = 0; g < ROWS; g++) begin : g_rom
        localparam logic [DATA_W-1:0] VAL = (g < DEPTH) ? atan_entry(g) : '0;
        assign rom[g] = VAL;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= rom[rd_addr];
        end
    end

    state_t            state;
    logic [ADDR_W:0]   remaining;
    logic [ADDR_W-1:0] next_idx;

    always_comb begin
        next_idx = s_idx + 1'b1;
        if (s_idx == ADDR_W'(DEPTH - 1)) next_idx = '0;
    end

    // remaining counts the word currently presented, so the last one is up when it reaches 1
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            busy      <= 1'b0;
            s_valid   <= 1'b0;
            s_data    <= '0;
            s_idx     <= '0;
            s_last    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && count != '0) begin
                        state     <= RUN;
                        remaining <= count;
                        busy      <= 1'b1;
                        s_valid   <= 1'b1;
                        s_idx     <= start_idx;
                        s_data    <= rom[start_idx];
                        s_last    <= (count == (ADDR_W + 1)'(1));
                    end
                end
                RUN: begin
                    if (s_ready) begin
                        if (s_last) begin
                            state     <= IDLE;
                            remaining <= '0;
                            busy      <= 1'b0;
                            s_valid   <= 1'b0;
                            s_last    <= 1'b0;
                        end else begin
                            remaining <= remaining - 1'b1;
                            s_idx     <= next_idx;
                            s_data    <= rom[next_idx];
                            s_last    <= (remaining == (ADDR_W + 1)'(2));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_atan_stream_rom.sv
// Directed bench for cordic_atan_stream_rom: random reads at two precisions, streams with
// backpressure, ignored starts and a mid-stream reset.
module tb_cordic_atan_stream_rom;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_en;
    logic [4:0]  rd_addr;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        start;
    logic [4:0]  start_idx;
    logic [5:0]  count;
    logic        busy;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic [4:0]  s_idx;
    logic        s_last;

    logic        b_rd_en;
    logic [4:0]  b_rd_addr;
    logic        b_rd_valid;
    logic [17:0] b_rd_data;
    logic        b_busy;
    logic        b_s_valid;
    logic [17:0] b_s_data;
    logic [4:0]  b_s_idx;
    logic        b_s_last;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cordic_atan_stream_rom dut (
        .clk(clk), .rst_n(rst_n),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
        .start(start), .start_idx(start_idx), .count(count), .busy(busy),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_idx(s_idx), .s_last(s_last)
    );

    cordic_atan_stream_rom #(.DATA_W(18), .FRAC_W(16), .DEPTH(32), .ADDR_W(5)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_valid(b_rd_valid), .rd_data(b_rd_data),
        .start(1'b0), .start_idx(5'd0), .count(6'd0), .busy(b_busy),
        .s_valid(b_s_valid), .s_ready(1'b1), .s_data(b_s_data), .s_idx(b_s_idx), .s_last(b_s_last)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic st, input logic [4:0] idx, input logic [5:0] cnt,
                                 input logic rdy);
        start     = st;
        start_idx = idx;
        count     = cnt;
        s_ready   = rdy;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [4:0]  addr_a [4];
        logic [31:0] exp_a  [4];
        logic [4:0]  addr_b [4];
        logic [17:0] exp_b  [4];
        logic [4:0]  tog_idx  [4];
        logic [31:0] tog_data [4];
        bit          pat [4];
        logic [31:0] e;
        int          t;

        addr_a = '{5'd0, 5'd20, 5'd31, 5'd30};
        exp_a  = '{32'h3243F6A9, 32'h00000400, 32'h00000000, 32'h00000001};
        addr_b = '{5'd0, 5'd17, 5'd15, 5'd16};
        exp_b  = '{18'h0C910, 18'h00000, 18'h00002, 18'h00001};
        tog_idx  = '{5'd30, 5'd31, 5'd0, 5'd1};
        tog_data = '{32'h00000001, 32'h00000000, 32'h3243F6A9, 32'h1DAC6705};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b0;
        rd_en = 1'b0; rd_addr = '0;
        b_rd_en = 1'b0; b_rd_addr = '0;
        applyStimulus(1'b0, 5'd0, 6'd0, 1'b0);
        tick;
        tick;
        checkOutput("reset_rd_valid", 64'(rd_valid), 64'd0);
        checkOutput("reset_rd_data", 64'(rd_data), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_s_valid", 64'(s_valid), 64'd0);
        checkOutput("reset_s_last", 64'(s_last), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            rd_en = 1'b1; rd_addr = addr_a[i];
            b_rd_en = 1'b1; b_rd_addr = addr_b[i];
            tick;
            checkOutput("rd_valid", 64'(rd_valid), 64'd1);
            checkOutput("rd_data_q30", 64'(rd_data), 64'(exp_a[i]));
            checkOutput("rd_data_q16", 64'(b_rd_data), 64'(exp_b[i]));
        end
        rd_en = 1'b0; b_rd_en = 1'b0; rd_addr = 5'd0;
        tick;
        checkOutput("rd_valid_drop", 64'(rd_valid), 64'd0);
        checkOutput("rd_data_hold", 64'(rd_data), 64'h1);
        checkOutput("rd_data_hold_q16", 64'(b_rd_data), 64'h1);

        // full index space from 0, with a stray start pulse partway through
        applyStimulus(1'b1, 5'd0, 6'd32, 1'b1);
        tick;
        for (int i = 0; i < 32; i++) begin
            applyStimulus(i == 10, 5'd5, 6'd3, 1'b1);
            checkOutput("full_s_valid", 64'(s_valid), 64'd1);
            checkOutput("full_busy", 64'(busy), 64'd1);
            checkOutput("full_s_idx", 64'(s_idx), 64'(i));
            checkOutput("full_s_last", 64'(s_last), 64'(i == 31));
            if (i == 0 || i >= 15) begin
                e = (i == 0) ? 32'h3243F6A9 : ((i == 31) ? 32'd0 : (32'd1 << (30 - i)));
                checkOutput("full_s_data", 64'(s_data), 64'(e));
            end
            tick;
        end
        applyStimulus(1'b0, 5'd0, 6'd0, 1'b1);
        checkOutput("full_end_valid", 64'(s_valid), 64'd0);
        checkOutput("full_end_busy", 64'(busy), 64'd0);
        checkOutput("full_end_last", 64'(s_last), 64'd0);

        applyStimulus(1'b1, 5'd7, 6'd0, 1'b1);
        tick;
        applyStimulus(1'b0, 5'd0, 6'd0, 1'b1);
        checkOutput("zero_count_busy", 64'(busy), 64'd0);
        checkOutput("zero_count_valid", 64'(s_valid), 64'd0);
        tick;
        checkOutput("zero_count_busy2", 64'(busy), 64'd0);

        // wrapping stream under backpressure; stalled cycles must repeat the same word
        applyStimulus(1'b1, 5'd30, 6'd4, 1'b0);
        tick;
        start = 1'b0;
        t = 0;
        for (int cyc = 0; cyc < 20 && t < 4; cyc++) begin
            checkOutput("tog_s_valid", 64'(s_valid), 64'd1);
            checkOutput("tog_s_idx", 64'(s_idx), 64'(tog_idx[t]));
            checkOutput("tog_s_data", 64'(s_data), 64'(tog_data[t]));
            checkOutput("tog_s_last", 64'(s_last), 64'(t == 3));
            s_ready = pat[cyc % 4];
            if (s_ready) t++;
            tick;
        end
        s_ready = 1'b1;
        checkOutput("tog_end_valid", 64'(s_valid), 64'd0);
        checkOutput("tog_end_busy", 64'(busy), 64'd0);
        tick;
        checkOutput("tog_no_extra", 64'(s_valid), 64'd0);

        applyStimulus(1'b1, 5'd10, 6'd8, 1'b1);
        tick;
        start = 1'b0;
        tick;
        tick;
        checkOutput("pre_reset_idx", 64'(s_idx), 64'd12);
        rst_n = 1'b0; rd_en = 1'b1; rd_addr = 5'd0;
        tick;
        rst_n = 1'b1; rd_en = 1'b0;
        checkOutput("mid_reset_rd_valid", 64'(rd_valid), 64'd0);
        checkOutput("mid_reset_rd_data", 64'(rd_data), 64'd0);
        checkOutput("mid_reset_busy", 64'(busy), 64'd0);
        checkOutput("mid_reset_s_valid", 64'(s_valid), 64'd0);
        checkOutput("mid_reset_s_data", 64'(s_data), 64'd0);
        checkOutput("mid_reset_s_idx", 64'(s_idx), 64'd0);
        checkOutput("mid_reset_s_last", 64'(s_last), 64'd0);

        applyStimulus(1'b1, 5'd3, 6'd2, 1'b1);
        tick;
        start = 1'b0;
        checkOutput("restart_valid", 64'(s_valid), 64'd1);
        checkOutput("restart_idx", 64'(s_idx), 64'd3);
        checkOutput("restart_last", 64'(s_last), 64'd0);
        tick;
        checkOutput("restart_idx2", 64'(s_idx), 64'd4);
        checkOutput("restart_last2", 64'(s_last), 64'd1);
        tick;
        checkOutput("restart_end", 64'(s_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
